// File: rtl/grayscale_word_packer.sv
// Packs an 8-bit pixel stream into PIXELS_PER_WORD-byte words, earliest pixel in byte 0.
// Optional byte-keep output is enabled by defining GRAYSCALE_PACKER_KEEP_EN.
`timescale 1ns/1ps
module grayscale_word_packer #(
  parameter int PIXELS_PER_WORD = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [7:0]                   pixel_i,
  input  logic                         pixel_valid_i,
  input  logic                         pixel_last_i,
  output logic                         pixel_ready_o,
  output logic [8*PIXELS_PER_WORD-1:0] word_o,
  output logic                         word_valid_o,
  output logic                         word_last_o,
  input  logic                         word_ready_i
`ifdef GRAYSCALE_PACKER_KEEP_EN
  ,
  output logic [PIXELS_PER_WORD-1:0]   word_keep_o
`endif
);

  localparam int P     = PIXELS_PER_WORD;
  localparam int W     = 8 * P;
  localparam int IDX_W = $clog2(P);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P - 1);

  logic [IDX_W-1:0]   r_idx;
  logic [8*(P-1)-1:0] r_acc;
  logic [W-1:0]       r_word;
  logic               r_valid;
  logic               r_last;

  logic               w_ready;
  logic               w_accept;
  logic               w_complete;
  logic [W-1:0]       w_word_next;

  // A pending word blocks input unless it is being taken this cycle.
  assign w_ready    = rst_ni && (!r_valid || word_ready_i);
  assign w_accept   = pixel_valid_i && w_ready;
  assign w_complete = w_accept && ((r_idx == LAST_IDX) || pixel_last_i);

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_byte
      if (gi < P - 1) begin : g_acc
        assign w_word_next[8*gi +: 8] = (r_idx == IDX_W'(gi)) ? pixel_i :
                                        (r_idx >  IDX_W'(gi)) ? r_acc[8*gi +: 8] : 8'h00;
      end else begin : g_top
        assign w_word_next[8*gi +: 8] = (r_idx == IDX_W'(gi)) ? pixel_i : 8'h00;
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_complete) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_idx <= r_idx + IDX_W'(1);
      for (int k = 0; k < P - 1; k++) begin
        if (r_idx == IDX_W'(k)) r_acc[8*k +: 8] <= pixel_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_word  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_complete) begin
      r_word  <= w_word_next;
      r_valid <= 1'b1;
      r_last  <= pixel_last_i;
    end else if (r_valid && word_ready_i) begin
      r_valid <= 1'b0;
    end
  end

`ifdef GRAYSCALE_PACKER_KEEP_EN
  logic [P-1:0] r_keep;
  logic [P-1:0] w_keep_next;

  // Thermometer mask covering bytes 0..idx.
  assign w_keep_next = ~({P{1'b1}} << (32'(r_idx) + 32'd1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_keep <= '0;
    end else if (w_complete) begin
      r_keep <= w_keep_next;
    end
  end

  assign word_keep_o = r_keep;
`endif

  assign pixel_ready_o = w_ready;
  assign word_o        = r_word;
  assign word_valid_o  = r_valid;
  assign word_last_o   = r_last;

endmodule

// File: tb/tb_grayscale_word_packer.sv
// Scoreboard bench: instance 0 uses 4 pixels/word (directed cases), instance 1 uses 8 (random run).
`timescale 1ns/1ps
module tb_grayscale_word_packer;

  typedef struct {
    logic [63:0] word;
    logic        last;
    logic [7:0]  keep;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix [2];
  logic       pv  [2];
  logic       pl  [2];
  logic       wr  [2];
  logic       pr  [2];
  logic       wv  [2];
  logic       wl  [2];
  logic [63:0] wd [2];
  logic [7:0]  kp [2];

  logic        pr4, wv4, wl4, pr8, wv8, wl8;
  logic [31:0] word4;
  logic [63:0] word8;
  logic [3:0]  keep4;
  logic [7:0]  keep8;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  logic [7:0] part_q[$];
  bit   pend_complete = 0;

  always #5 clk = ~clk;

  grayscale_word_packer #(.PIXELS_PER_WORD(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .pixel_i(pix[0]), .pixel_valid_i(pv[0]),
    .pixel_last_i(pl[0]), .pixel_ready_o(pr4), .word_o(word4), .word_valid_o(wv4),
    .word_last_o(wl4), .word_ready_i(wr[0])
`ifdef GRAYSCALE_PACKER_KEEP_EN
    , .word_keep_o(keep4)
`endif
  );

  grayscale_word_packer #(.PIXELS_PER_WORD(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .pixel_i(pix[1]), .pixel_valid_i(pv[1]),
    .pixel_last_i(pl[1]), .pixel_ready_o(pr8), .word_o(word8), .word_valid_o(wv8),
    .word_last_o(wl8), .word_ready_i(wr[1])
`ifdef GRAYSCALE_PACKER_KEEP_EN
    , .word_keep_o(keep8)
`endif
  );

`ifndef GRAYSCALE_PACKER_KEEP_EN
  assign keep4 = 4'h0;
  assign keep8 = 8'h0;
`endif

  assign pr[0] = pr4;  assign pr[1] = pr8;
  assign wv[0] = wv4;  assign wv[1] = wv8;
  assign wl[0] = wl4;  assign wl[1] = wl8;
  assign wd[0] = {32'h0, word4};
  assign wd[1] = word8;
  assign kp[0] = {4'h0, keep4};
  assign kp[1] = keep8;

  function automatic int ppw(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: collect pixels of the current word, emit on fill or end of line.
  task automatic model_push(input int d, input logic [7:0] px, input logic l);
    exp_t e;
    part_q.push_back(px);
    if (part_q.size() == ppw(d) || l) begin
      e.word = 64'h0;
      for (int i = 0; i < part_q.size(); i++) e.word = e.word | (64'(part_q[i]) << (8 * i));
      e.keep = 8'((1 << part_q.size()) - 1);
      e.last = l;
      exp_q.push_back(e);
      part_q.delete();
      pend_complete = 1;
    end else begin
      pend_complete = 0;
    end
  endtask

  task automatic cycle(input int d, input bit v, input logic [7:0] px, input bit l,
                       input bit wrdy, output bit acc);
    @(negedge clk);
    if (pend_complete) check("word_latency_valid", 64'(wv[d]), 64'd1);
    pv[d] = v; pix[d] = px; pl[d] = l; wr[d] = wrdy;
    #1;
    check("pixel_ready_rule", 64'(pr[d]), 64'(rst_n && (!wv[d] || wrdy)));
    acc = v && pr[d];
    if (acc) model_push(d, px, l);
    else pend_complete = 0;
  endtask

  task automatic send(input int d, input logic [7:0] px, input bit l, input bit wrdy);
    bit acc;
    int budget;
    acc = 0;
    budget = 0;
    while (!acc && budget < 200) begin
      cycle(d, 1'b1, px, l, wrdy, acc);
      budget++;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got no accept required accept of pixel %0h", px);
    end
  endtask

  task automatic drain(input int d, input int n);
    bit acc;
    repeat (n) cycle(d, 1'b0, 8'h00, 1'b0, 1'b1, acc);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin pv[d] = 0; wr[d] = 1; end
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_pixel_ready", 64'(pr[d]), 64'd0);
      check("rst_word", wd[d], 64'd0);
      check("rst_word_valid", 64'(wv[d]), 64'd0);
      check("rst_word_last", 64'(wl[d]), 64'd0);
      check("rst_word_keep", 64'(kp[d]), 64'd0);
    end
    part_q.delete();
    exp_q.delete();
    pend_complete = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitors pop the scoreboard on each transfer and check that stalled words hold.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    initial begin : mon
      logic [64:0] held;
      bit          stall;
      exp_t        e;
      stall = 0;
      held  = '0;
      forever begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
          stall = 0;
        end else begin
          if (stall) check("stall_hold", {wl[gi], wd[gi]}, held);
          if (wv[gi] && wr[gi]) begin
            if (exp_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected_word: got %0h required none", wd[gi]);
            end else begin
              e = exp_q.pop_front();
              check("word_data", wd[gi], e.word);
              check("word_last", 64'(wl[gi]), 64'(e.last));
`ifdef GRAYSCALE_PACKER_KEEP_EN
              check("word_keep", 64'(kp[gi]), 64'(e.keep));
`endif
            end
          end
          stall = wv[gi] && !wr[gi];
          held  = {wl[gi], wd[gi]};
        end
      end
    end
  end

  initial begin
    bit acc;
    for (int d = 0; d < 2; d++) begin pix[d] = 0; pv[d] = 0; pl[d] = 0; wr[d] = 1; end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("init_pixel_ready", 64'(pr[d]), 64'd0);
      check("init_word_valid", 64'(wv[d]), 64'd0);
      check("init_word", wd[d], 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Two full words back to back.
    for (int i = 0; i < 8; i++) send(0, 8'(8'h10 + i), i == 7, 1'b1);
    drain(0, 3);

    // Full word then a one-pixel partial.
    for (int i = 0; i < 5; i++) send(0, 8'(8'hA0 + i), i == 4, 1'b1);
    drain(0, 3);

    // Single-pixel line.
    send(0, 8'hFF, 1'b1, 1'b1);
    drain(0, 3);

    // Backpressure: first word pending, further pixels must be refused.
    for (int i = 0; i < 4; i++) send(0, 8'(8'h40 + i), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1'b1, 8'h50, 1'b0, 1'b0, acc);
      check("stall_no_accept", 64'(acc), 64'd0);
    end
    for (int i = 0; i < 6; i++) send(0, 8'(8'h50 + i), i == 5, 1'b1);
    drain(0, 4);
    check("directed_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-word discards the partial pixels.
    send(0, 8'h01, 1'b0, 1'b1);
    send(0, 8'h02, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) send(0, 8'(8'h21 + i), i == 3, 1'b1);
    drain(0, 3);
    check("reset_queue_empty", 64'(exp_q.size()), 64'd0);

    // Random traffic on the 8-pixel instance.
    for (int n = 0; n < 1024; n++) begin
      logic [7:0] px;
      int budget;
      px = 8'($urandom);
      acc = 0;
      budget = 0;
      while (!acc && budget < 200) begin
        cycle(1, $urandom_range(0, 3) != 0, px, (n % 13) == 12,
              $urandom_range(0, 2) != 0, acc);
        budget++;
      end
      if (!acc) begin
        n_tests++; n_fail++;
        $display("FAIL random_timeout: got no accept required accept of pixel %0d", n);
      end
    end
    drain(1, 4);
    check("random_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
